// File: rtl/adc_acq_multi.sv
// adc_acq_multi: multi-lane serial ADC burst acquisition with clock-enable SCLK/FSYNC and analog MUX stepping
// Ports:
//   dsp_clk_60M_in   - sole clock, all logic on its rising edge
//   dsp_rst_in       - synchronous active-high reset
//   dsp_adc_en_in    - start request, rising edge starts a burst
//   dsp_adc_abort_in - level abort, returns to idle on the next edge
//   dsp_ch_en_in     - per-lane enable (disabled lanes report zero)
//   adc_data_in      - serial data, bit k = lane k, sampled on SCLK rise
//   adc_sclk_out     - ADC serial clock
//   adc_fsync_out    - frame sync, high for one SCLK period before each frame
//   adc_pwdn_out     - active-low power-down, registered lane enables
//   adc_data_out     - truncated words, lane k at [k*DATA_BITS +: DATA_BITS]
//   data_valid_out   - one-cycle strobe with new adc_data_out
//   convert_over_out - one-cycle strobe at burst completion
//   busy_out         - high outside IDLE
//   start_err_out    - sticky, start requested while busy
//   pt_mux_out       - analog MUX select
module adc_acq_multi #(
    parameter int NUM_CH     = 3,
    parameter int FRAME_BITS = 24,
    parameter int DATA_BITS  = 16,
    parameter int SCLK_HALF  = 6,
    parameter int BURST_LEN  = 80,
    parameter int MUX_W      = 2,
    parameter int MUX_NUM    = 4,
    parameter int MUX_MODE   = 0
) (
    input  logic                        dsp_clk_60M_in,
    input  logic                        dsp_rst_in,
    input  logic                        dsp_adc_en_in,
    input  logic                        dsp_adc_abort_in,
    input  logic [NUM_CH-1:0]           dsp_ch_en_in,
    input  logic [NUM_CH-1:0]           adc_data_in,
    output logic                        adc_sclk_out,
    output logic                        adc_fsync_out,
    output logic [NUM_CH-1:0]           adc_pwdn_out,
    output logic [NUM_CH*DATA_BITS-1:0] adc_data_out,
    output logic                        data_valid_out,
    output logic                        convert_over_out,
    output logic                        busy_out,
    output logic                        start_err_out,
    output logic [MUX_W-1:0]            pt_mux_out
);
    localparam int DW = $clog2(SCLK_HALF);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int FW = $clog2(BURST_LEN + 1);
    localparam logic [DW-1:0]    DIV_LAST   = DW'(SCLK_HALF - 1);
    localparam logic [BW-1:0]    BIT_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0]    BIT_FULL   = BW'(FRAME_BITS);
    localparam logic [FW-1:0]    FRAME_LAST = FW'(BURST_LEN - 1);
    localparam logic [MUX_W-1:0] MUX_LAST   = MUX_W'(MUX_NUM - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT, DONE} state_t;
    state_t state, state_nx;

    logic                  en_d, start, tick, rise, fall, last_rise, frame_end;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FW-1:0]         frame_cnt;
    logic [FRAME_BITS-1:0] shift_q  [NUM_CH];
    logic [FRAME_BITS-1:0] shift_nx [NUM_CH];

    assign start     = dsp_adc_en_in & ~en_d;
    assign tick      = (state == SYNC || state == SHIFT) && div_cnt == DIV_LAST;
    assign rise      = tick & ~adc_sclk_out;
    assign fall      = tick & adc_sclk_out;
    // The last rise of a frame completes the word; the frame ends at the fall after it.
    assign last_rise = rise && state == SHIFT && bit_cnt == BIT_LAST;
    assign frame_end = fall && state == SHIFT && bit_cnt == BIT_FULL;
    assign busy_out  = state != IDLE;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            shift_nx[k] = {shift_q[k][FRAME_BITS-2:0], adc_data_in[k]};
    end

    always_ff @(posedge dsp_clk_60M_in)
        state <= dsp_rst_in ? IDLE : state_nx;

    // Abort dominates every transition, including start in IDLE and entry to DONE.
    always_comb begin
        state_nx = state;
        if (dsp_adc_abort_in)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = start ? SYNC : IDLE;
                SYNC:    state_nx = fall ? SHIFT : SYNC;
                SHIFT:   state_nx = frame_end ? (frame_cnt == FRAME_LAST ? DONE : SYNC) : SHIFT;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge dsp_clk_60M_in) begin
        if (dsp_rst_in) begin
            en_d             <= 1'b0;
            div_cnt          <= '0;
            bit_cnt          <= '0;
            frame_cnt        <= '0;
            adc_sclk_out     <= 1'b0;
            adc_fsync_out    <= 1'b0;
            adc_pwdn_out     <= '1;
            adc_data_out     <= '0;
            data_valid_out   <= 1'b0;
            convert_over_out <= 1'b0;
            start_err_out    <= 1'b0;
            pt_mux_out       <= '0;
            for (int k = 0; k < NUM_CH; k++)
                shift_q[k] <= '0;
        end else begin
            en_d             <= dsp_adc_en_in;
            adc_pwdn_out     <= dsp_ch_en_in;
            adc_fsync_out    <= state_nx == SYNC;
            data_valid_out   <= last_rise && !dsp_adc_abort_in;
            convert_over_out <= state_nx == DONE;
            if (start && state != IDLE)
                start_err_out <= 1'b1;
            else if (state == IDLE && state_nx == SYNC)
                start_err_out <= 1'b0;
            // SCLK restarts low with a fresh divider at every frame and is parked low when idle.
            if (state_nx == IDLE || state_nx == DONE || (state_nx == SYNC && state != SYNC)) begin
                div_cnt      <= '0;
                adc_sclk_out <= 1'b0;
            end else if (tick) begin
                div_cnt      <= '0;
                adc_sclk_out <= ~adc_sclk_out;
            end else
                div_cnt <= div_cnt + 1'b1;
            bit_cnt   <= state != SHIFT ? '0 : rise ? bit_cnt + 1'b1 : bit_cnt;
            frame_cnt <= state == IDLE ? '0 : (state == SHIFT && state_nx == SYNC) ? frame_cnt + 1'b1 : frame_cnt;
            if (state == SHIFT && rise)
                for (int k = 0; k < NUM_CH; k++)
                    shift_q[k] <= shift_nx[k];
            if (last_rise && !dsp_adc_abort_in)
                for (int k = 0; k < NUM_CH; k++)
                    adc_data_out[k*DATA_BITS +: DATA_BITS] <= dsp_ch_en_in[k] ? shift_nx[k][FRAME_BITS-1 -: DATA_BITS] : '0;
            if (MUX_MODE != 0 ? data_valid_out : convert_over_out)
                pt_mux_out <= pt_mux_out == MUX_LAST ? '0 : pt_mux_out + 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_acq_multi.sv
// tb_adc_acq_multi: directed-sequence bench with random frame data for adc_acq_multi
module tb_adc_acq_multi;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, abort = 1'b0;
    logic [2:0]  ch_en = '0;
    logic [2:0]  din;
    logic        sclk, fsync, valid, over, busy, err;
    logic [2:0]  pwdn;
    logic [47:0] dout;
    logic [1:0]  mux;
    logic        sclk_b, fsync_b, valid_b, over_b, busy_b, err_b;
    logic [2:0]  pwdn_b;
    logic [47:0] dout_b;
    logic [1:0]  mux_b;

    int passed = 0, failed = 0, total = 0, now = 0;
    int mux1_exp = 0, mux0_exp = 0;
    bit err_exp = 1'b0;
    int bit_idx = 0;
    logic [23:0] cur [3];

    adc_acq_multi #(.BURST_LEN(2), .MUX_NUM(3), .MUX_MODE(1)) u1 (
        .dsp_clk_60M_in(clk), .dsp_rst_in(rst), .dsp_adc_en_in(en), .dsp_adc_abort_in(abort),
        .dsp_ch_en_in(ch_en), .adc_data_in(din), .adc_sclk_out(sclk), .adc_fsync_out(fsync),
        .adc_pwdn_out(pwdn), .adc_data_out(dout), .data_valid_out(valid), .convert_over_out(over),
        .busy_out(busy), .start_err_out(err), .pt_mux_out(mux));

    adc_acq_multi #(.BURST_LEN(2), .MUX_NUM(3), .MUX_MODE(0)) u0 (
        .dsp_clk_60M_in(clk), .dsp_rst_in(rst), .dsp_adc_en_in(en), .dsp_adc_abort_in(abort),
        .dsp_ch_en_in(ch_en), .adc_data_in(din), .adc_sclk_out(sclk_b), .adc_fsync_out(fsync_b),
        .adc_pwdn_out(pwdn_b), .adc_data_out(dout_b), .data_valid_out(valid_b), .convert_over_out(over_b),
        .busy_out(busy_b), .start_err_out(err_b), .pt_mux_out(mux_b));

    always #5 clk = ~clk;

    // ADC model: fsync rewinds to the MSB, each SCLK rise outside fsync moves to the next bit.
    always @(posedge sclk or posedge fsync) bit_idx = fsync ? 0 : bit_idx + 1;
    always_comb
        for (int k = 0; k < 3; k++)
            din[k] = bit_idx < 24 ? cur[k][23 - bit_idx] : 1'b0;

    task automatic step();
        @(negedge clk);
        now++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int w);
        case (w)
            0:       return valid;
            1:       return over;
            2:       return !fsync;
            3:       return sclk;
            4:       return !sclk;
            5:       return valid || over;
            default: return bit_idx == 10;
        endcase
    endfunction

    task automatic wait_for(input int w, input int limit, output int cyc);
        cyc = 0;
        while (!cond(w) && cyc < limit) begin
            step();
            cyc++;
        end
    endtask

    function automatic logic [47:0] model(input logic [2:0] lanes);
        logic [47:0] r = '0;
        for (int k = 0; k < 3; k++)
            r[k*16 +: 16] = lanes[k] ? 16'(cur[k] / 24'd256) : 16'd0;
        return r;
    endfunction

    task automatic new_words();
        for (int k = 0; k < 3; k++)
            cur[k] = 24'($urandom);
    endtask

    task automatic do_start();
        en = 1'b1;
        step();
        en = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err_clear", err, 0);
        err_exp = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_sclk", sclk, 0);
        chk("rst_fsync", fsync, 0);
        chk("rst_pwdn", pwdn, 3'b111);
        chk("rst_data", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_over", over, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mux", mux, 0);
        chk("rst_mux_burst", mux_b, 0);
        mux1_exp = 0;
        mux0_exp = 0;
        err_exp  = 1'b0;
    endtask

    task automatic run_burst(input logic [2:0] lanes, input int poke, input bit timed);
        int t0, c;
        ch_en = lanes;
        if (!timed) new_words();
        do_start();
        t0 = now;
        if (timed) begin
            chk("fsync_start", fsync, 1);
            wait_for(2, 40, c);
            chk("fsync_high_cycles", c, 12);
            wait_for(3, 40, c);
            chk("first_rise_delay", c, 6);
            wait_for(4, 40, c);
            chk("sclk_high_cycles", c, 6);
            wait_for(3, 40, c);
            chk("sclk_low_cycles", c, 6);
        end
        if (poke > 0) begin
            repeat (poke) step();
            en = 1'b1;
            step();
            en = 1'b0;
            chk("start_err_set", err, 1);
            chk("busy_kept", busy, 1);
            err_exp = 1'b1;
        end
        for (int f = 0; f < 2; f++) begin
            wait_for(0, 400, c);
            chk("valid_time", now - t0, 294 + 300 * f);
            chk("rises_per_frame", bit_idx, 24);
            chk("data", dout, model(lanes));
            if (timed && f == 0) chk("data_directed", dout, 48'hFFFF_1234_A5A5);
            chk("mux_at_valid", mux, mux1_exp);
            mux1_exp = (mux1_exp + 1) % 3;
            new_words();
            step();
            chk("valid_one_cycle", valid, 0);
        end
        wait_for(1, 20, c);
        chk("over_time", now - t0, 600);
        chk("busy_at_over", busy, 1);
        step();
        chk("over_one_cycle", over, 0);
        chk("idle_after_over", busy, 0);
        mux0_exp = (mux0_exp + 1) % 3;
        chk("mux_per_burst", mux_b, mux0_exp);
        chk("pwdn_copy", pwdn, lanes);
        chk("start_err_hold", err, err_exp);
    endtask

    initial begin
        int t0, c;
        logic [47:0] held;
        for (int k = 0; k < 3; k++) cur[k] = '0;
        repeat (3) step();
        reset_checks();
        rst = 1'b0;
        step();
        chk("pwdn_follow", pwdn, 3'b000);
        cur[0] = 24'hA5A53C;
        cur[1] = 24'h123456;
        cur[2] = 24'hFFFF00;
        run_burst(3'b111, 0, 1'b1);
        run_burst(3'b111, 0, 1'b0);
        run_burst(3'b111, 100, 1'b0);
        ch_en = 3'b111;
        new_words();
        do_start();
        t0 = now;
        wait_for(0, 400, c);
        chk("abort_f0_time", now - t0, 294);
        held = model(3'b111);
        chk("abort_f0_data", dout, held);
        chk("abort_f0_mux", mux, mux1_exp);
        mux1_exp = (mux1_exp + 1) % 3;
        new_words();
        step();
        wait_for(6, 400, c);
        chk("abort_point", now - t0, 426);
        abort = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_sclk", sclk, 0);
        chk("abort_fsync", fsync, 0);
        abort = 1'b0;
        wait_for(5, 400, c);
        chk("abort_no_pulse", c, 400);
        chk("abort_data_held", dout, held);
        chk("abort_mux", mux, mux1_exp);
        chk("abort_mux_burst", mux_b, mux0_exp);
        en = 1'b1;
        abort = 1'b1;
        step();
        chk("start_abort_idle", busy, 0);
        en = 1'b0;
        abort = 1'b0;
        step();
        run_burst(3'b111, 0, 1'b0);
        run_burst(3'b101, 0, 1'b0);
        ch_en = 3'b101;
        new_words();
        do_start();
        repeat (150) step();
        rst = 1'b1;
        step();
        reset_checks();
        rst = 1'b0;
        step();
        run_burst(3'b111, 0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
